// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the canonical NOP word and a small alignment helper.
// No ports.

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf
// Synchronous FIFO holding fetched {pc, instr} pairs for the decoder.
// DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop all entries (wins over push/pop)
//   push, push_data     write an entry (accepted when not full, or full with pop)
//   pop, pop_data       remove the head entry; pop_data always shows the head
//   full, empty, count  occupancy status

module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end: issues single-outstanding word fetches to
// instruction memory, buffers responses and presents them in order.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   o_imem_req/o_imem_addr/i_imem_gnt   request channel (held until granted)
//   i_imem_rvalid/i_imem_rdata          response channel
//   o_instr/o_pc/o_valid/i_ready        decoder handshake
//   i_redirect/i_redirect_pc            taken branch / jump target
//   o_misaligned                        sticky misaligned-target flag
//
// state   | meaning
// IDLE    | no room in buffer, or halted on a misaligned target
// REQ     | request driven, waiting for grant
// WAIT    | request granted, waiting for its response
// DROP    | response in flight belongs to a redirected-away stream; discard it

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misaligned
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_n;
    logic          misaligned;
    logic          misaligned_n;
    logic          req_q;
    logic          issue;
    logic          push;
    logic          pop;
    logic          in_flight;
    logic          target_ok;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          buf_full;
    logic          buf_empty;
    logic [63:0]   head;

    // Redirect outranks every same-cycle push, pop and grant.
    assign issue       = req_q && i_imem_gnt;
    assign push        = (state == ST_WAIT) && i_imem_rvalid && !i_redirect;
    assign pop         = !buf_empty && i_ready && !i_redirect;
    assign count_after = count + CW'(push) - CW'(pop);
    assign target_ok   = is_aligned(i_redirect_pc[1:0]);

    // A response is still owed after this edge: either one was already
    // pending and does not arrive now, or a new request is being granted.
    assign in_flight = (((state == ST_WAIT) || (state == ST_DROP)) && !i_imem_rvalid)
                       || issue;

    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        misaligned_n = misaligned;
        if (i_redirect) begin
            if (target_ok) begin
                fetch_pc_n   = i_redirect_pc;
                misaligned_n = 1'b0;
            end else begin
                misaligned_n = 1'b1;
            end
            if (in_flight) begin
                state_n = ST_DROP;
            end else if (!target_ok) begin
                state_n = ST_IDLE;
            end else begin
                state_n = ST_REQ;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!misaligned && (!buf_full || pop)) begin
                        state_n = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (issue) begin
                        state_n = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = (count_after < CW'(BUF_DEPTH)) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (i_imem_rvalid) begin
                        state_n = (!misaligned && (count_after < CW'(BUF_DEPTH)))
                                  ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // req_q mirrors "state is REQ" except during reset, where the FSM sits in
    // REQ but the request stays low until the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_REQ;
            fetch_pc   <= RESET_PC;
            misaligned <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            misaligned <= misaligned_n;
            req_q      <= (state_n == ST_REQ);
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_buf (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect),
        .push      (push),
        .push_data ({fetch_pc, i_imem_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (count)
    );

    assign o_imem_req   = req_q;
    assign o_imem_addr  = fetch_pc;
    assign o_valid      = !buf_empty;
    assign o_pc         = head[63:32];
    assign o_instr      = head[31:0];
    assign o_misaligned = misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misaligned;

    int checks;
    int errors;

    // memory responder / scoreboard state
    int          lat;
    int          pend_cnt;
    int          pend_epoch;
    int          epoch;
    int          grant_cnt;
    logic [31:0] pend_addr;
    logic [63:0] exp_q[$];
    logic [31:0] grant_addrs[$];

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_misaligned  (o_misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle, entered and left at a falling edge. Inputs for the
    // coming rising edge are already set by the caller.
    task automatic cycle();
        logic        deliver;
        logic        granted;
        logic [63:0] exp;
        int          g_epoch;
        deliver       = (pend_cnt == 1);
        i_imem_rvalid = deliver;
        i_imem_rdata  = deliver ? mem_word(pend_addr) : 32'h0;
        if (deliver && pend_epoch == epoch) exp_q.push_back({pend_addr, mem_word(pend_addr)});
        checks++;
        if (o_imem_req && pend_cnt != 0) begin
            errors++;
            $display("FAIL single_outstanding: req=%b while response pending=%0d, required req=0",
                     o_imem_req, pend_cnt);
        end
        granted = o_imem_req && i_imem_gnt;
        g_epoch = epoch;
        if (i_redirect) begin
            exp_q.delete();
            epoch++;
        end else if (o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got pc=%h instr=%h, required no output",
                         o_pc, o_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({o_pc, o_instr} !== exp) begin
                    errors++;
                    $display("FAIL scoreboard: got pc=%h instr=%h, required pc=%h instr=%h",
                             o_pc, o_instr, exp[63:32], exp[31:0]);
                end
            end
        end
        if (granted) begin
            grant_cnt++;
            grant_addrs.push_back(o_imem_addr);
            pend_addr  = o_imem_addr;
            pend_epoch = g_epoch;
        end
        @(posedge i_clk);
        if (pend_cnt > 0) pend_cnt--;
        if (granted) pend_cnt = lat;
        @(negedge i_clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        cycle();
        i_redirect    = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_valid, o_imem_req, o_misaligned} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: valid/req/mis=%b, required 000",
                     {o_valid, o_imem_req, o_misaligned});
        end
        checks++;
        if ({o_instr, o_pc} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h pc=%h, required 0/0", o_instr, o_pc);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, required 1/00000000", o_imem_req, o_imem_addr);
        end
    endtask

    task automatic test_first_fetch();
        cycle();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency: valid=%b during response cycle, required 0", o_valid);
        end
        cycle();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h0050_0093) begin
            errors++;
            $display("FAIL first_fetch: valid=%b pc=%h instr=%h, required 1/00000000/00500093",
                     o_valid, o_pc, o_instr);
        end
    endtask

    task automatic test_backpressure();
        repeat (8) cycle();
        checks++;
        if (grant_cnt != 2) begin
            errors++;
            $display("FAIL bp_grants: grants=%0d, required 2", grant_cnt);
        end
        checks++;
        if (o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_req: req=%b, required 0", o_imem_req);
        end
        checks++;
        if (o_instr !== 32'h0050_0093 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold: instr=%h pc=%h, required 00500093/00000000", o_instr, o_pc);
        end
        i_ready = 1'b1;
        repeat (6) cycle();
    endtask

    task automatic test_stream();
        int pops;
        pops = 0;
        for (int i = 0; i < 60; i++) begin
            lat     = $urandom_range(1, 3);
            i_ready = 1'($urandom_range(0, 1));
            if (o_valid && i_ready) pops++;
            cycle();
        end
        checks++;
        if (pops < 5) begin
            errors++;
            $display("FAIL stream_progress: pops=%0d, required at least 5", pops);
        end
        lat     = 1;
        i_ready = 1'b1;
        repeat (6) cycle();
    endtask

    task automatic test_redirect_drop();
        bit found;
        i_ready = 1'b0;
        lat     = 3;
        redirect(32'h0000_0080);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (pend_cnt == 3 && pend_epoch == epoch) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drop_grant_timeout: no grant seen, required one within 20 cycles");
        end
        redirect(32'h0000_0100);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_flush: valid=%b after redirect, required 0", o_valid);
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (o_valid) found = 1;
        end
        checks++;
        if (!found || o_pc !== 32'h0000_0100 || o_instr !== mem_word(32'h0000_0100)) begin
            errors++;
            $display("FAIL drop_target: valid=%b pc=%h instr=%h, required 1/00000100/%h",
                     o_valid, o_pc, o_instr, mem_word(32'h0000_0100));
        end
        i_ready = 1'b1;
        lat     = 1;
        repeat (8) cycle();
    endtask

    task automatic test_misaligned();
        int  g0;
        bit  saw_req;
        redirect(32'h0000_0102);
        g0      = grant_cnt;
        saw_req = 0;
        repeat (8) begin
            cycle();
            if (o_imem_req) saw_req = 1;
        end
        checks++;
        if (o_misaligned !== 1'b1) begin
            errors++;
            $display("FAIL mis_flag: misaligned=%b, required 1", o_misaligned);
        end
        checks++;
        if (saw_req || grant_cnt != g0) begin
            errors++;
            $display("FAIL mis_no_req: saw_req=%0d grants=%0d, required 0/%0d", saw_req, grant_cnt, g0);
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_valid: valid=%b, required 0", o_valid);
        end
        redirect(32'h0000_0200);
        checks++;
        if (o_misaligned !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL mis_clear: mis=%b req=%b addr=%h, required 0/1/00000200",
                     o_misaligned, o_imem_req, o_imem_addr);
        end
        repeat (8) cycle();
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFC);
        grant_addrs.delete();
        repeat (10) cycle();
        checks++;
        if (grant_addrs.size() < 2) begin
            errors++;
            $display("FAIL wrap_grants: grants=%0d, required at least 2", grant_addrs.size());
        end else if (grant_addrs[0] !== 32'hFFFF_FFFC || grant_addrs[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: addrs=%h,%h, required FFFFFFFC,00000000",
                     grant_addrs[0], grant_addrs[1]);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        i_ready = 1'b0;
        lat     = 4;
        redirect(32'h0000_0040);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (o_valid && pend_cnt > 1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL arst_setup_timeout: valid=%b pend=%0d, required mid-WAIT with data", o_valid, pend_cnt);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_imem_req, o_misaligned} !== 3'b000) begin
            errors++;
            $display("FAIL arst_flags: valid/req/mis=%b, required 000", {o_valid, o_imem_req, o_misaligned});
        end
        checks++;
        if ({o_instr, o_pc} !== 64'h0 || o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL arst_data: instr=%h pc=%h addr=%h, required 0/0/0", o_instr, o_pc, o_imem_addr);
        end
        pend_cnt      = 0;
        i_imem_rvalid = 1'b0;
        exp_q.delete();
        epoch++;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL arst_release: req=%b addr=%h, required 1/00000000", o_imem_req, o_imem_addr);
        end
        i_ready = 1'b1;
        lat     = 1;
        repeat (10) cycle();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        lat           = 1;
        pend_cnt      = 0;
        pend_epoch    = 0;
        epoch         = 0;
        grant_cnt     = 0;
        pend_addr     = 32'h0;
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_stream();
        test_redirect_drop();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
